// File: rtl/ssd_display_driver_if.sv
// ssd_display_driver_if
//   Value link between the CPU top and the seven-segment driver.
//   num  : binary value to display (0..8191), driven by the CPU side
//   busy : 1 while the driver is converting num to BCD
//   bcd  : last completed BCD result {thousands,hundreds,tens,ones}
//   Modports: master = CPU side, slave = display driver.
interface ssd_display_driver_if;
    logic [12:0] num;
    logic        busy;
    logic [15:0] bcd;

    modport master (output num, input  busy, input  bcd);
    modport slave  (input  num, output busy, output bcd);
endinterface

// File: rtl/ssd_display_driver.sv
// ssd_display_driver
//   Converts a 13-bit binary value to BCD with an iterative double-dabble
//   FSM (one bit per clock) and scans the four BCD digits onto a
//   multiplexed, active-low seven-segment display.
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous reset, active-low
//   cpu    : slave side of ssd_display_driver_if (num in; busy, bcd out)
//   anode  : digit enables, active-low, anode[0] = ones digit
//   seg    : cathodes {g,f,e,d,c,b,a}, active-low
// Parameters
//   REFRESH_W : refresh counter width; digit advances every 2^(REFRESH_W-2) clks
//   BLANK_LZ  : 1 = blank leading zero digits (ones digit never blanked)
module ssd_display_driver #(
    parameter int unsigned REFRESH_W = 18,
    parameter bit          BLANK_LZ  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    ssd_display_driver_if.slave      cpu,
    output logic [3:0]               anode,
    output logic [6:0]               seg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [12:0]            shift_q,   shift_d;
    logic [15:0]            scratch_q, scratch_d;
    logic [12:0]            last_q,    last_d;
    logic [3:0]             bitcnt_q,  bitcnt_d;
    logic                   force_q,   force_d;
    logic                   busy_q,    busy_d;
    logic [15:0]            bcd_q,     bcd_d;
    logic [REFRESH_W-1:0]   refresh_q, refresh_d;
    logic [3:0]             anode_q,   anode_d;
    logic [6:0]             seg_q,     seg_d;

    logic [15:0]            adj;
    logic [1:0]             digit;
    logic [3:0]             nib;
    logic [3:0]             lead_zero;

    function automatic logic [6:0] seg_pattern(input logic [3:0] n);
        case (n)
            4'd0:    seg_pattern = 7'h40;
            4'd1:    seg_pattern = 7'h79;
            4'd2:    seg_pattern = 7'h24;
            4'd3:    seg_pattern = 7'h30;
            4'd4:    seg_pattern = 7'h19;
            4'd5:    seg_pattern = 7'h12;
            4'd6:    seg_pattern = 7'h02;
            4'd7:    seg_pattern = 7'h78;
            4'd8:    seg_pattern = 7'h00;
            4'd9:    seg_pattern = 7'h10;
            default: seg_pattern = 7'h7F;
        endcase
    endfunction

    // Conversion FSM next-state logic
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        last_d    = last_q;
        bitcnt_d  = bitcnt_q;
        force_d   = force_q;
        busy_d    = busy_q;
        bcd_d     = bcd_q;

        // Add-3 correction on every BCD nibble that is 5 or more before the shift
        adj = scratch_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (force_q || (cpu.num != last_q)) begin
                    shift_d   = cpu.num;
                    last_d    = cpu.num;
                    scratch_d = '0;
                    bitcnt_d  = '0;
                    force_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[14:0], shift_q[12]};
                shift_d   = {shift_q[11:0], 1'b0};
                bitcnt_d  = bitcnt_q + 4'd1;
                if (bitcnt_q == 4'd12) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                bcd_d   = scratch_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Display scan: outputs are registered from the current digit index and bcd
    always_comb begin
        refresh_d = refresh_q + {{(REFRESH_W-1){1'b0}}, 1'b1};
        digit     = refresh_q[REFRESH_W-1 -: 2];
        nib       = bcd_q[{digit, 2'b00} +: 4];

        // lead_zero[k]: nibbles k..3 are all zero
        lead_zero[3] = (bcd_q[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (bcd_q[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (bcd_q[7:4] == 4'd0);
        lead_zero[0] = 1'b0;

        anode_d = ~(4'b0001 << digit);
        if (BLANK_LZ && lead_zero[digit]) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = seg_pattern(nib);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            last_q    <= '0;
            bitcnt_q  <= '0;
            force_q   <= 1'b1;
            busy_q    <= 1'b0;
            bcd_q     <= '0;
            refresh_q <= '0;
            anode_q   <= '1;
            seg_q     <= '1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            last_q    <= last_d;
            bitcnt_q  <= bitcnt_d;
            force_q   <= force_d;
            busy_q    <= busy_d;
            bcd_q     <= bcd_d;
            refresh_q <= refresh_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign cpu.busy = busy_q;
    assign cpu.bcd  = bcd_q;
    assign anode    = anode_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
// tb_ssd_display_driver
//   Two instances (REFRESH_W=4): u_dut0 without blanking, u_dut1 with
//   leading-zero blanking. Conversion results go through a scoreboard queue.
module tb_ssd_display_driver;

    logic       clk;
    logic       rst;
    logic [3:0] anode0, anode1;
    logic [6:0] seg0,   seg1;

    ssd_display_driver_if if0 ();
    ssd_display_driver_if if1 ();

    ssd_display_driver #(.REFRESH_W(4), .BLANK_LZ(1'b0)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .cpu   (if0),
        .anode (anode0),
        .seg   (seg0)
    );

    ssd_display_driver #(.REFRESH_W(4), .BLANK_LZ(1'b1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .cpu   (if1),
        .anode (anode1),
        .seg   (seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [15:0] bcd;
    } sb_t;

    typedef struct {
        logic [12:0] num;
        logic [15:0] bcd;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? if1.busy : if0.busy;
    endfunction

    function automatic logic [15:0] get_bcd(input int sel);
        return (sel != 0) ? if1.bcd : if0.bcd;
    endfunction

    function automatic logic [3:0] get_anode(input int sel);
        return (sel != 0) ? anode1 : anode0;
    endfunction

    function automatic logic [6:0] get_seg(input int sel);
        return (sel != 0) ? seg1 : seg0;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", nm, $time);
    endtask

    task automatic start_conv(input int sel, input logic [12:0] v, input logic [15:0] e);
        int n = 0;
        while (get_busy(sel) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) fail_now("idle_wait");
        @(negedge clk);
        if (sel != 0) if1.num = v; else if0.num = v;
        sbq.push_back('{sel, e});
        @(posedge clk); #1;
        check("capture_busy", 32'(get_busy(sel)), 32'd1);
    endtask

    task automatic finish_conv(input int sel, input int n0);
        int  n = n0;
        sb_t s;
        while (get_busy(sel) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, 14);
        if (sbq.size() == 0) begin
            fail_now("scoreboard_empty");
        end else begin
            s = sbq.pop_front();
            check("bcd", get_bcd(s.sel), 32'(s.bcd));
        end
    endtask

    task automatic scan_check(input int sel, input logic [15:0] exp_bcd, input bit blank);
        logic [3:0] an_tab [4];
        int         n;
        int         k;
        logic [6:0] exp_seg;
        logic [15:0] upper;
        an_tab[0] = 4'hE; an_tab[1] = 4'hD; an_tab[2] = 4'hB; an_tab[3] = 4'h7;
        n = 0;
        while (get_anode(sel) != 4'h7 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 64) fail_now("scan_sync7");
        n = 0;
        while (get_anode(sel) != 4'hE && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 64) fail_now("scan_syncE");
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            k = (i / 4) % 4;
            upper = exp_bcd >> (4 * k);
            if (blank && k > 0 && upper == 16'h0) exp_seg = 7'h7F;
            else exp_seg = seg_of(4'(upper));
            check("scan_anode", get_anode(sel), an_tab[k]);
            check("scan_seg", get_seg(sel), exp_seg);
        end
    endtask

    initial begin
        vecs[0]  = '{13'd1,    16'h0001};
        vecs[1]  = '{13'd9,    16'h0009};
        vecs[2]  = '{13'd10,   16'h0010};
        vecs[3]  = '{13'd99,   16'h0099};
        vecs[4]  = '{13'd100,  16'h0100};
        vecs[5]  = '{13'd999,  16'h0999};
        vecs[6]  = '{13'd1000, 16'h1000};
        vecs[7]  = '{13'd4095, 16'h4095};
        vecs[8]  = '{13'd5000, 16'h5000};
        vecs[9]  = '{13'd7,    16'h0007};
        vecs[10] = '{13'd8191, 16'h8191};
        vecs[11] = '{13'd1234, 16'h1234};

        rst     = 1'b0;
        if0.num = 13'd0;
        if1.num = 13'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_anode0", anode0, 4'hF);
        check("rst_seg0",   seg0,   7'h7F);
        check("rst_bcd0",   if0.bcd, 16'h0);
        check("rst_busy0",  if0.busy, 1'b0);
        check("rst_anode1", anode1, 4'hF);
        check("rst_seg1",   seg1,   7'h7F);

        // Release with num=0: the forced first conversion runs on both instances
        @(negedge clk);
        rst = 1'b1;
        sbq.push_back('{0, 16'h0000});
        @(posedge clk); #1;
        check("first_capture_busy", if0.busy, 1'b1);
        finish_conv(0, 0);
        check("first_bcd1",  if1.bcd, 16'h0);
        check("first_busy1", if1.busy, 1'b0);

        // A constant num must not retrigger a conversion
        repeat (5) begin
            @(posedge clk); #1;
            check("idle_no_retrigger", if0.busy, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            start_conv(0, vecs[i].num, vecs[i].bcd);
            finish_conv(0, 0);
        end

        scan_check(0, 16'h1234, 1'b0);

        start_conv(0, 13'd7, 16'h0007);
        finish_conv(0, 0);
        scan_check(0, 16'h0007, 1'b0);

        start_conv(1, 13'd7, 16'h0007);
        finish_conv(1, 0);
        scan_check(1, 16'h0007, 1'b1);
        start_conv(1, 13'd0, 16'h0000);
        finish_conv(1, 0);
        scan_check(1, 16'h0000, 1'b1);

        // num changes mid-SHIFT: first result is the old value, then reconvert
        start_conv(0, 13'd100, 16'h0100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        if0.num = 13'd250;
        sbq.push_back('{0, 16'h0250});
        finish_conv(0, 5);
        @(negedge clk);
        @(posedge clk); #1;
        check("reconv_busy", if0.busy, 1'b1);
        finish_conv(0, 0);

        // Reset during SHIFT aborts; conversion restarts after release
        start_conv(0, 13'd4095, 16'h4095);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_anode", anode0, 4'hF);
        check("abort_seg",   seg0,   7'h7F);
        check("abort_bcd",   if0.bcd, 16'h0);
        check("abort_busy",  if0.busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("restart_busy", if0.busy, 1'b1);
        finish_conv(0, 0);
        check("restart_bcd1", if1.bcd, 16'h0);

        check("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
